// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: funct3 size codes, FSM states,
// and the wait-state ceiling.
package dmem_pkg;

  typedef enum logic [2:0] {
    SZ_B  = 3'b000,
    SZ_H  = 3'b001,
    SZ_W  = 3'b010,
    SZ_BU = 3'b100,
    SZ_HU = 3'b101
  } mem_size_e;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } dmem_state_e;

  localparam int MAX_WAIT_CYCLES = 15;

  // True for the five funct3 codes the responder supports.
  function automatic logic size_legal(input logic [2:0] size);
    case (size)
      SZ_B, SZ_H, SZ_W, SZ_BU, SZ_HU: return 1'b1;
      default:                        return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_unit.sv
// Byte-lane steering for the data-memory responder: byte enables and lane
// replication for stores, lane selection and sign/zero extension for loads.
// Halfword lane uses addr[1] only and words ignore addr[1:0], so unaligned
// addresses naturally fall back to the aligned location.
module dmem_lane_unit
  import dmem_pkg::*;
(
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  size,
  input  logic [31:0] wdata,
  input  logic [31:0] rdata_raw,
  output logic [3:0]  be,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata_ext
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Decode lanes from size/offset; illegal sizes enable nothing and read zero.
  always_comb begin
    byte_sel   = rdata_raw[8*addr_lo +: 8];
    half_sel   = addr_lo[1] ? rdata_raw[31:16] : rdata_raw[15:0];
    be         = 4'b0000;
    wdata_lane = 32'h0;
    rdata_ext  = 32'h0;
    case (size)
      SZ_B, SZ_BU: begin
        be         = 4'b0001 << addr_lo;
        wdata_lane = {4{wdata[7:0]}};
        rdata_ext  = (size == SZ_B) ? {{24{byte_sel[7]}}, byte_sel} : {24'h0, byte_sel};
      end
      SZ_H, SZ_HU: begin
        be         = addr_lo[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata_ext  = (size == SZ_H) ? {{16{half_sel[15]}}, half_sel} : {16'h0, half_sel};
      end
      SZ_W: begin
        be         = 4'b1111;
        wdata_lane = wdata;
        rdata_ext  = rdata_raw;
      end
      default: begin
        be         = 4'b0000;
        wdata_lane = 32'h0;
        rdata_ext  = 32'h0;
      end
    endcase
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder with programmable wait states and byte-lane stores.
// Optional feature macro: DMEM_ALIGN_CHECK_EN (misaligned H/HU/W raise rsp_err
// instead of being masked to the aligned location).
// Timing: the acceptance edge captures the request and reads the RAM word;
// the counter then drains WAIT_CYCLES wait states and the following edge
// performs the access and enters RESP, i.e. rsp_valid rises WAIT_CYCLES+1
// edges after acceptance.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DEPTH_WORDS = 1024,
  parameter int WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_size,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);

  localparam int          AW         = $clog2(DEPTH_WORDS);
  localparam logic [32:0] BYTE_LIMIT = 33'(4 * DEPTH_WORDS);
  localparam logic [3:0]  WAIT_LOAD  =
    4'((WAIT_CYCLES > MAX_WAIT_CYCLES) ? MAX_WAIT_CYCLES : WAIT_CYCLES);

  dmem_state_e state_reg, state_next;
  logic [3:0]  cnt_reg, cnt_next;

  logic        we_reg;
  logic [31:0] addr_reg;
  logic [31:0] wdata_reg;
  logic [2:0]  size_reg;
  logic [31:0] rd_word_reg;

  logic [31:0] mem [DEPTH_WORDS];

  logic        accept;
  logic        access;
  logic        rsp_done;
  logic        out_of_range;
  logic        misaligned;
  logic        err;
  logic [3:0]  be;
  logic [31:0] wdata_lane;
  logic [31:0] rdata_ext;

  assign req_ready    = (state_reg == IDLE) && !rst;
  assign accept       = req_valid && req_ready;
  assign access       = (state_reg == WAIT) && (cnt_reg == 4'd0);
  assign rsp_done     = (state_reg == RESP) && rsp_ready;
  assign out_of_range = {1'b0, addr_reg} >= BYTE_LIMIT;

`ifdef DMEM_ALIGN_CHECK_EN
  // Flag halfword/word accesses whose low address bits are not zero.
  always_comb begin
    misaligned = 1'b0;
    case (size_reg)
      SZ_H, SZ_HU: misaligned = addr_reg[0];
      SZ_W:        misaligned = |addr_reg[1:0];
      default:     misaligned = 1'b0;
    endcase
  end
`else
  assign misaligned = 1'b0;
`endif

  assign err = out_of_range || !size_legal(size_reg) || misaligned;

  dmem_lane_unit u_lane (
    .addr_lo    (addr_reg[1:0]),
    .size       (size_reg),
    .wdata      (wdata_reg),
    .rdata_raw  (rd_word_reg),
    .be         (be),
    .wdata_lane (wdata_lane),
    .rdata_ext  (rdata_ext)
  );

  // Next-state and wait-counter logic.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (accept) begin
          state_next = WAIT;
          cnt_next   = WAIT_LOAD;
        end
      end
      WAIT: begin
        if (cnt_reg == 4'd0) state_next = RESP;
        else                 cnt_next   = cnt_reg - 4'd1;
      end
      RESP: begin
        if (rsp_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // State and counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  // Capture the request on acceptance; reset drops it via the state register.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_reg    <= req_we;
      addr_reg  <= req_addr;
      wdata_reg <= req_wdata;
      size_reg  <= req_size;
    end
  end

  // Registered RAM read at acceptance and byte-enabled write on RESP entry.
  // Contents survive reset; a store interrupted by reset never writes.
  always_ff @(posedge clk) begin
    if (accept) rd_word_reg <= mem[req_addr[AW+1:2]];
    if (!rst && access && we_reg && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[addr_reg[AW+1:2]][8*b +: 8] <= wdata_lane[8*b +: 8];
      end
    end
  end

  // Response registers: set on RESP entry, held until the handshake.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end else if (access) begin
      rsp_valid <= 1'b1;
      rsp_err   <= err;
      rsp_rdata <= (err || we_reg) ? 32'h0 : rdata_ext;
    end else if (rsp_done) begin
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'h0;
      rsp_err   <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed self-checking bench for dmem_responder (WAIT_CYCLES=2, 1024 words).
// Build with +define+DMEM_ALIGN_CHECK_EN to check the alignment-error variant.
module tb_dmem_responder;

  localparam int DEPTH = 1024;
  localparam int WAITS = 2;

  logic        clk;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [2:0]  req_size;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  int tests = 0;
  int fails = 0;

  dmem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(WAITS)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .req_size  (req_size),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // One complete transaction: request, bounded wait for response, handshake.
  task automatic txn(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [2:0] size, output logic [31:0] rdata, output logic err,
                     output int lat);
    @(negedge clk);
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata; req_size = size;
    @(posedge clk); #1;
    req_valid = 1'b0;
    lat = 0;
    while (!rsp_valid && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    tests++;
    if (!rsp_valid) begin
      fails++;
      $display("[TB] FAIL txn_timeout: got no rsp_valid after %0d edges, required within 40", lat);
    end
    rdata = rsp_rdata;
    err   = rsp_err;
    $display("[TB] txn we=%0b addr=%h wdata=%h size=%b -> rdata=%h err=%0b lat=%0d",
             we, addr, wdata, size, rdata, err, lat);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = 3'b010; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL reset_req_ready: got %b required 0", req_ready); end
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_valid: got %b required 0", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("[TB] FAIL reset_rsp_rdata: got %h required 0", rsp_rdata); end
    tests++; if (rsp_err !== 1'b0) begin fails++; $display("[TB] FAIL reset_rsp_err: got %b required 0", rsp_err); end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_reset_req_ready: got %b required 1", req_ready); end
  endtask

  task automatic test_word();
    logic [31:0] d; logic e; int l;
    txn(1'b1, 32'h10, 32'hDEADBEEF, 3'b010, d, e, l);
    tests++; if (l !== WAITS + 1) begin fails++; $display("[TB] FAIL store_latency: got %0d required %0d", l, WAITS + 1); end
    tests++; if (e !== 1'b0) begin fails++; $display("[TB] FAIL store_w_err: got %b required 0", e); end
    tests++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL store_w_rdata: got %h required 0", d); end
    txn(1'b0, 32'h10, 32'h0, 3'b010, d, e, l);
    tests++; if (d !== 32'hDEADBEEF) begin fails++; $display("[TB] FAIL load_w: got %h required deadbeef", d); end
    tests++; if (l !== WAITS + 1) begin fails++; $display("[TB] FAIL load_latency: got %0d required %0d", l, WAITS + 1); end
  endtask

  task automatic test_byte();
    logic [31:0] d; logic e; int l;
    txn(1'b1, 32'h10, 32'h0, 3'b010, d, e, l);
    txn(1'b1, 32'h11, 32'h00000080, 3'b000, d, e, l);
    txn(1'b0, 32'h10, 32'h0, 3'b010, d, e, l);
    tests++; if (d !== 32'h00008000) begin fails++; $display("[TB] FAIL byte_merge: got %h required 00008000", d); end
    txn(1'b0, 32'h11, 32'h0, 3'b000, d, e, l);
    tests++; if (d !== 32'hFFFFFF80) begin fails++; $display("[TB] FAIL load_b: got %h required ffffff80", d); end
    txn(1'b0, 32'h11, 32'h0, 3'b100, d, e, l);
    tests++; if (d !== 32'h00000080) begin fails++; $display("[TB] FAIL load_bu: got %h required 00000080", d); end
  endtask

  task automatic test_half();
    logic [31:0] d; logic e; int l;
    txn(1'b1, 32'h20, 32'h0, 3'b010, d, e, l);
    txn(1'b1, 32'h22, 32'h1234ABCD, 3'b001, d, e, l);
    txn(1'b0, 32'h22, 32'h0, 3'b001, d, e, l);
    tests++; if (d !== 32'hFFFFABCD) begin fails++; $display("[TB] FAIL load_h: got %h required ffffabcd", d); end
    txn(1'b0, 32'h20, 32'h0, 3'b101, d, e, l);
    tests++; if (d !== 32'h0) begin fails++; $display("[TB] FAIL load_hu_low: got %h required 00000000", d); end
    txn(1'b0, 32'h20, 32'h0, 3'b010, d, e, l);
    tests++; if (d !== 32'hABCD0000) begin fails++; $display("[TB] FAIL half_merge: got %h required abcd0000", d); end
  endtask

  // Response back-pressure, then back-to-back acceptance of a pending request.
  task automatic test_stall();
    int l; logic held_ok;
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h10; req_size = 3'b010;
    @(posedge clk); #1;
    req_addr = 32'h20;   // next request stays presented and must be ignored for now
    l = 0;
    while (!rsp_valid && l < 40) begin @(posedge clk); #1; l++; end
    tests++; if (l !== WAITS + 1) begin fails++; $display("[TB] FAIL stall_latency: got %0d required %0d", l, WAITS + 1); end
    held_ok = 1'b1;
    for (int c = 0; c < 5; c++) begin
      if (rsp_valid !== 1'b1 || rsp_rdata !== 32'h00008000 || req_ready !== 1'b0) held_ok = 1'b0;
      @(posedge clk); #1;
    end
    tests++; if (held_ok !== 1'b1) begin fails++; $display("[TB] FAIL stall_hold: got valid=%b rdata=%h ready=%b required 1/00008000/0", rsp_valid, rsp_rdata, req_ready); end
    $display("[TB] txn stalled load addr=00000010 -> rdata=%h", rsp_rdata);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    tests++; if (rsp_valid !== 1'b0) begin fails++; $display("[TB] FAIL post_hs_valid: got %b required 0", rsp_valid); end
    tests++; if (rsp_rdata !== 32'h0) begin fails++; $display("[TB] FAIL post_hs_rdata: got %h required 0", rsp_rdata); end
    tests++; if (req_ready !== 1'b1) begin fails++; $display("[TB] FAIL post_hs_ready: got %b required 1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL b2b_accept: got req_ready=%b required 0", req_ready); end
    l = 0;
    while (!rsp_valid && l < 40) begin @(posedge clk); #1; l++; end
    tests++; if (rsp_rdata !== 32'hABCD0000 || l !== WAITS + 1) begin fails++; $display("[TB] FAIL b2b_load: got %h lat %0d required abcd0000 lat %0d", rsp_rdata, l, WAITS + 1); end
    $display("[TB] txn back-to-back load addr=00000020 -> rdata=%h lat=%0d", rsp_rdata, l);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
  endtask

  task automatic test_errors();
    logic [31:0] d; logic e; int l;
    txn(1'b1, 32'h0, 32'h0, 3'b010, d, e, l);
    txn(1'b1, 32'h1000, 32'h11111111, 3'b010, d, e, l);
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("[TB] FAIL oor_store: got err=%b rdata=%h required 1/0", e, d); end
    txn(1'b0, 32'h0, 32'h0, 3'b010, d, e, l);
    tests++; if (e !== 1'b0 || d !== 32'h0) begin fails++; $display("[TB] FAIL oor_no_alias: got err=%b rdata=%h required 0/0", e, d); end
    txn(1'b0, 32'h1000, 32'h0, 3'b010, d, e, l);
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("[TB] FAIL oor_load: got err=%b rdata=%h required 1/0", e, d); end
    txn(1'b1, 32'h30, 32'h55AA55AA, 3'b010, d, e, l);
    txn(1'b1, 32'h30, 32'hFFFFFFFF, 3'b011, d, e, l);
    tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL size011_err: got %b required 1", e); end
    txn(1'b1, 32'h30, 32'hFFFFFFFF, 3'b110, d, e, l);
    tests++; if (e !== 1'b1) begin fails++; $display("[TB] FAIL size110_err: got %b required 1", e); end
    txn(1'b0, 32'h30, 32'h0, 3'b010, d, e, l);
    tests++; if (d !== 32'h55AA55AA || e !== 1'b0) begin fails++; $display("[TB] FAIL illegal_no_write: got %h err=%b required 55aa55aa/0", d, e); end
    txn(1'b0, 32'h30, 32'h0, 3'b111, d, e, l);
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("[TB] FAIL size111_load: got err=%b rdata=%h required 1/0", e, d); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] d; logic e; int l; logic seen;
    txn(1'b1, 32'h40, 32'hCAFEF00D, 3'b010, d, e, l);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 32'h40; req_wdata = 32'h99999999; req_size = 3'b010;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    seen = 1'b0;
    repeat (2) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    tests++; if (req_ready !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_ready: got %b required 0", req_ready); end
    rst = 1'b0;
    repeat (6) begin @(posedge clk); #1; if (rsp_valid) seen = 1'b1; end
    tests++; if (seen !== 1'b0) begin fails++; $display("[TB] FAIL mid_rst_valid: got rsp_valid seen=%b required 0", seen); end
    $display("[TB] txn store addr=00000040 wdata=99999999 aborted by reset");
    txn(1'b0, 32'h40, 32'h0, 3'b010, d, e, l);
    tests++; if (d !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL mid_rst_nowrite: got %h required cafef00d", d); end
  endtask

  task automatic test_align();
    logic [31:0] d; logic e; int l;
    txn(1'b0, 32'h42, 32'h0, 3'b010, d, e, l);
`ifdef DMEM_ALIGN_CHECK_EN
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("[TB] FAIL align_w: got err=%b rdata=%h required 1/0", e, d); end
`else
    tests++; if (e !== 1'b0 || d !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL align_w: got err=%b rdata=%h required 0/cafef00d", e, d); end
`endif
    txn(1'b0, 32'h43, 32'h0, 3'b101, d, e, l);
`ifdef DMEM_ALIGN_CHECK_EN
    tests++; if (e !== 1'b1 || d !== 32'h0) begin fails++; $display("[TB] FAIL align_hu: got err=%b rdata=%h required 1/0", e, d); end
`else
    tests++; if (e !== 1'b0 || d !== 32'h0000CAFE) begin fails++; $display("[TB] FAIL align_hu: got err=%b rdata=%h required 0/0000cafe", e, d); end
`endif
    txn(1'b1, 32'h41, 32'h00001234, 3'b001, d, e, l);
    txn(1'b0, 32'h40, 32'h0, 3'b010, d, e, l);
`ifdef DMEM_ALIGN_CHECK_EN
    tests++; if (d !== 32'hCAFEF00D) begin fails++; $display("[TB] FAIL align_h_store: got %h required cafef00d", d); end
`else
    tests++; if (d !== 32'hCAFE1234) begin fails++; $display("[TB] FAIL align_h_store: got %h required cafe1234", d); end
`endif
  endtask

  initial begin
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_stall();
    test_errors();
    test_reset_mid();
    test_align();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
